// File: rtl/zeroheti_apb_to_obi.sv
// APB completer to OBI manager bridge: one OBI request/response per APB transfer.
// Optional grant timeout enabled by defining ZEROHETI_APB2OBI_TIMEOUT_EN.
module zeroheti_apb_to_obi #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [DataWidth-1:0]   pwdata_i,
    input  logic [DataWidth/8-1:0] pstrb_i,
    output logic [DataWidth-1:0]   prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   we_o,
    output logic [DataWidth/8-1:0] be_o,
    output logic [DataWidth-1:0]   wdata_o,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i,
    input  logic                   err_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    state_e state_q;

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    // Word-aligned OBI address; the byte offset bits carry no meaning here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^paddr_i[1:0];

`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] tmo_cnt_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_o     <= 1'b0;
            addr_o    <= '0;
            we_o      <= 1'b0;
            be_o      <= '0;
            wdata_o   <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            prdata_o  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        addr_o  <= {paddr_i[AddrWidth-1:2], 2'b00};
                        we_o    <= pwrite_i;
                        wdata_o <= pwdata_i;
                        be_o    <= pwrite_i ? pstrb_i : {BeWidth{1'b1}};
                        if (pwrite_i && pstrb_i == '0) begin
                            state_q  <= DONE;
                            pready_o <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_o   <= 1'b1;
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (gnt_i) begin
                        state_q <= RESP;
                        req_o   <= 1'b0;
`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
                    end else if (tmo_cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                        state_q   <= DONE;
                        req_o     <= 1'b0;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rvalid_i) begin
                        state_q   <= DONE;
                        pready_o  <= 1'b1;
                        pslverr_o <= err_i;
                        prdata_o  <= we_o ? '0 : rdata_i;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zeroheti_apb_to_obi.sv
// Testbench for zeroheti_apb_to_obi: directed cases plus randomized transfers
// checked against a transaction-level latency/data model.
module tb_zeroheti_apb_to_obi;

    localparam int Tmo = 8;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    zeroheti_apb_to_obi #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(Tmo)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .pstrb_i  (pstrb),
        .prdata_o (prdata),
        .pready_o (pready),
        .pslverr_o(pslverr),
        .req_o    (req),
        .gnt_i    (gnt),
        .addr_o   (addr),
        .we_o     (we),
        .be_o     (be),
        .wdata_o  (wdata),
        .rvalid_i (rvalid),
        .rdata_i  (rdata),
        .err_i    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One APB transfer with an OBI subordinate that grants after gw wait
    // cycles and responds after rw wait cycles. tmo: never grant.
    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sb,
                        input int gw, input int rw,
                        input logic [31:0] rd, input logic er,
                        input bit drop_psel, input bit tmo);
        bit zero;
        bit granted;
        bit done;
        int nreq;
        int nresp;
        int exp_lat;
        logic [31:0] exp_rd;
        logic exp_er;
        zero    = wr && (sb == 4'h0);
        granted = 0;
        done    = 0;
        nreq    = 0;
        nresp   = 0;
        if (zero) begin
            exp_lat = 1;
            exp_rd  = 32'h0;
            exp_er  = 1'b0;
        end else if (tmo) begin
            exp_lat = 1 + Tmo;
            exp_rd  = 32'h0;
            exp_er  = 1'b1;
        end else begin
            exp_lat = 3 + gw + rw;
            exp_rd  = wr ? 32'h0 : rd;
            exp_er  = er;
        end
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = sb;
        rvalid  = 1'b0;
        @(posedge clk);
        #1 penable = 1'b1;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (drop_psel && k == 2) begin
                psel    = 1'b0;
                penable = 1'b0;
            end
            if (pready) begin
                check("latency", 32'(k), 32'(exp_lat));
                check("prdata", prdata, exp_rd);
                check("pslverr", 32'(pslverr), 32'(exp_er));
                if (tmo) check("tmo_req_cycles", 32'(nreq), 32'(Tmo));
                done   = 1;
                gnt    = 1'b0;
                rvalid = 1'b0;
            end else if (req) begin
                if (zero) check("zero_strb_req", 32'(req), 32'h0);
                check("addr_o", addr, {a[31:2], 2'b00});
                check("we_o", 32'(we), 32'(wr));
                check("be_o", 32'(be), wr ? 32'(sb) : 32'hF);
                check("wdata_o", wdata, wd);
                gnt    = !tmo && (nreq == gw);
                rvalid = 1'($urandom_range(0, 1));
                rdata  = $urandom;
                err    = 1'($urandom_range(0, 1));
                if (gnt) granted = 1;
                nreq++;
            end else if (granted) begin
                gnt    = 1'b0;
                rvalid = (nresp == rw);
                rdata  = rvalid ? rd : $urandom;
                err    = rvalid ? er : 1'($urandom_range(0, 1));
                nresp++;
            end
        end
        if (!done) check("pready_timeout", 32'h0, 32'h1);
        gnt    = 1'b0;
        rvalid = 1'b0;
        @(negedge clk);
        check("pready_one_cycle", 32'(pready), 32'h0);
        check("pslverr_idle", 32'(pslverr), 32'h0);
        check("prdata_idle", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        // Stray response while idle must be ignored.
        rvalid  = 1'b1;
        err     = 1'b1;
        @(negedge clk);
        rvalid  = 1'b0;
        err     = 1'b0;
        check("idle_no_pready", 32'(pready), 32'h0);
        check("idle_no_req", 32'(req), 32'h0);
    endtask

    initial begin
        logic        wr;
        logic [3:0]  sb;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        err     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_req", 32'(req), 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_be", 32'(be), 32'h0);
        check("rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;

        xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 0, 0, 32'hCAFEBABE, 1'b0, 0, 0);
        xfer(1'b1, 32'h0000_2003, 32'h12345678, 4'b0011, 3, 1, 32'hDEAD0000,
             1'b0, 0, 0);
        xfer(1'b0, 32'h0000_3008, 32'h0, 4'h0, 1, 2, 32'h55AA55AA, 1'b1, 0, 0);
        xfer(1'b1, 32'h0000_400C, 32'hFFFF0000, 4'h0, 0, 0, 32'h0, 1'b0, 0, 0);
        xfer(1'b0, 32'h0000_5000, 32'h0, 4'h0, 2, 1, 32'h01234567, 1'b0, 1, 0);

        // Reset while waiting for the response; late rvalid must be dropped.
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0000_6000;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        check("rr_req", 32'(req), 32'h1);
        gnt = 1'b1;
        @(negedge clk);
        gnt   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hBAD0BAD0;
        check("rr_req_low", 32'(req), 32'h0);
        check("rr_addr_clr", addr, 32'h0);
        check("rr_be_clr", 32'(be), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr_no_pready", 32'(pready), 32'h0);
        end
        rvalid = 1'b0;
        xfer(1'b0, 32'h0000_6004, 32'h0, 4'h0, 0, 0, 32'h600D600D, 1'b0, 0, 0);

`ifdef ZEROHETI_APB2OBI_TIMEOUT_EN
        xfer(1'b0, 32'h0000_7000, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 0, 1);
        xfer(1'b0, 32'h0000_7004, 32'h0, 4'h0, Tmo - 1, 0, 32'h77777777,
             1'b0, 0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            xfer(wr, $urandom, $urandom, sb, $urandom_range(0, 4),
                 $urandom_range(0, 3), $urandom, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
